// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter between N_PORTS requesters and a single-ported memory.
//   One transaction at a time: IDLE (arbitrate and latch) -> ISSUE (one-cycle
//   strobe) -> WAIT (LATENCY cycles) -> RESP (one-cycle ack to the granted port).
//
// Ports
//   CLK, RES      clock, asynchronous active-low reset
//   req, we       per-port request / write enable (bit i = port i)
//   addr, wdata   per-port address / write data, port i at [i*W +: W]
//   ack           one-hot completion pulse, one cycle
//   rdata         read data, valid in the ack cycle of a read, held otherwise
//   busy          high whenever the FSM is not idle
//   memRead/memWrite/memAddr/memDataIn   memory request side
//   memDataOut    memory read data
module mem_arbiter #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic                        CLK,
  input  logic                        RES,
  input  logic [N_PORTS-1:0]          req,
  input  logic [N_PORTS-1:0]          we,
  input  logic [N_PORTS*ADDR_W-1:0]   addr,
  input  logic [N_PORTS*DATA_W-1:0]   wdata,
  output logic [N_PORTS-1:0]          ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic                        memRead,
  output logic                        memWrite,
  output logic [ADDR_W-1:0]           memAddr,
  output logic [DATA_W-1:0]           memDataIn,
  input  logic [DATA_W-1:0]           memDataOut
);

  localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       g_q, g_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_l_q, we_l_d;
  logic [ADDR_W-1:0]   addr_l_q, addr_l_d;
  logic [DATA_W-1:0]   wdata_l_q, wdata_l_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [ADDR_W-1:0]   addr_a  [N_PORTS];
  logic [DATA_W-1:0]   wdata_a [N_PORTS];

  logic                found;
  logic [PW-1:0]       pick;
  logic [CW-1:0]       cand;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
    assign addr_a[p]  = addr[p*ADDR_W +: ADDR_W];
    assign wdata_a[p] = wdata[p*DATA_W +: DATA_W];
  end

  // First requester at or above ptr, wrapping; cand carries one extra bit so
  // ptr+k can exceed N_PORTS-1 before the modulo fold.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(N_PORTS)) begin
        cand = cand - CW'(N_PORTS);
      end
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
    we_l_d    = we_l_q;
    addr_l_d  = addr_l_q;
    wdata_l_d = wdata_l_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          g_d       = pick;
          we_l_d    = we[pick];
          addr_l_d  = addr_a[pick];
          wdata_l_d = wdata_a[pick];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 4'(LATENCY);
        ptr_d   = (g_q == PW'(N_PORTS - 1)) ? '0 : g_q + PW'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          if (!we_l_q) begin
            rdata_d = memDataOut;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      g_q       <= '0;
      cnt_q     <= '0;
      we_l_q    <= 1'b0;
      addr_l_q  <= '0;
      wdata_l_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      cnt_q     <= cnt_d;
      we_l_q    <= we_l_d;
      addr_l_q  <= addr_l_d;
      wdata_l_q <= wdata_l_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ST_RESP) begin
      ack[g_q] = 1'b1;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign memRead   = (state_q == ST_ISSUE) && !we_l_q;
  assign memWrite  = (state_q == ST_ISSUE) &&  we_l_q;
  assign memAddr   = addr_l_q;
  assign memDataIn = wdata_l_q;
  assign rdata     = rdata_q;

endmodule
